modulador_pcode: RTL and testbench
==================================

// Module: modulador_pcode
// PURPOSE
//  Parametrised phase-code (BPSK) pulse modulator for the HFSWR transmit chain, between the carrier
//  source (NCO/DDS) and the DAC. While sinc is high, it modulates the offset-binary carrier sample
//  stream with a loadable binary code of programmable length and programmable chip duration.
//  Outside the code window the DAC sits at midscale. Unlike the fixed 16-chip modulator, code
//  length, chip length and data width are runtime/parameter controlled, with status outputs.
// PARAMETERS
//  DATA_W   14   carrier/DAC sample width, offset binary
//  CODE_W   64   code register width = max chips per pulse
//  LEN_W     7   width of cod_len (must hold CODE_W)
//  CHIP_W   16   width of chip_len (samples per chip)
//  ZERO     (1<<(DATA_W-1))-1   midscale output (14'h1FFF at default)
// PORTS
//  clk         in   1        system clock
//  rst         in   1        synchronous, active-high reset
//  sinc        in   1        pulse gate; rising edge starts a code, low forces midscale
//  cod         in   CODE_W   code bits; chip i uses cod[cod_len-1-i] (MSB of used field first)
//  cod_len     in   LEN_W    chips per pulse; 0 or >CODE_W means CODE_W
//  chip_len    in   CHIP_W   samples per chip; 0 means 1
//  senial      in   DATA_W   carrier sample, one per clk
//  senial_mod  out  DATA_W   modulated sample to DAC
//  chip_idx    out  LEN_W    chip index of the sample on senial_mod
//  busy        out  1        senial_mod carries modulated code samples
//  code_done   out  1        1-cycle pulse, coincident with last sample of last chip on senial_mod
// BEHAVIOUR
//  Reset: the design is synchronous-reset only; clk and rst are the only clock/reset. Reset
//   outputs: senial_mod=ZERO, chip_idx=0, busy=0, code_done=0, FSM=IDLE, pipeline flushed.
//   Reset wins over a coincident sinc rising edge.
//  FSM (sampled each clk): IDLE -> RUN on sinc rise (sinc=1, previous sinc=0). RUN -> TAIL after
//   the final sample of chip cod_len-1. RUN/TAIL -> IDLE whenever sinc=0.
//   TAIL -> RUN is not allowed; a new code needs sinc to go low for >=1 clk, then high again.
//  Config latch: cod, cod_len, chip_len are captured on the sinc-rise edge. Changes during RUN/TAIL
//   are ignored until the next pulse.
//  Chip timing: the sample taken on the rise edge is sample 0 of chip 0. Each chip lasts exactly
//   chip_len samples, so the code spans cod_len*chip_len samples.
//  Mixing: bit=1 -> out=senial; bit=0 -> out=~senial (phase inversion about midscale in offset binary).
//   IDLE/TAIL/sinc=0 -> out=ZERO.
//  Latency: 2 clk, fixed (input register + mix register). The sample presented at edge t appears
//   on senial_mod at edge t+2. busy, chip_idx and code_done are delayed to the same alignment.
//  sinc falling mid-code: the sample on that edge is not modulated (ZERO two clocks later).
//   Samples already in the pipeline complete, and code_done is not issued.
//  chip_idx counts 0..cod_len-1 with no wrap. It is held at 0 while busy=0.
// CONFIGURATION
//  GOLAY_PAIR_EN defined:
//   - Adds input cod_b[CODE_W-1:0] and output code_sel (1 bit, aligned with senial_mod).
//   - Successive pulses alternate cod (code_sel=0) and cod_b (code_sel=1); the first pulse after
//     reset uses cod.
//   - An aborted pulse still toggles the selection.
//  GOLAY_PAIR_EN undefined: cod_b and code_sel do not exist, and every pulse uses cod.
// STRUCTURE
//  hfswr_pkg.vh: FSM state encodings (IDLE/RUN/TAIL) and the ZERO midscale macro, shared with
//   the other DAC-path blocks.
//  Sub-module pcode_chip_seq: FSM, config latch, sample/chip counters and current bit.
//   Outputs bit, active, chip_idx, last. Top level holds the 2-stage mixer pipeline.
// TESTING
//  1 rst=1 for 3 clk with sinc=1 -> senial_mod=14'h1FFF, busy=0. After release, no RUN until sinc
//    falls and rises again.
//  2 cod=64'hB, cod_len=4, chip_len=2, senial=14'h2000 constant, sinc pulse of 12 clk.
//    Output from rise+2: 2000,2000, 1FFF,1FFF, 2000,2000, 2000,2000. code_done on the 8th sample.
//    Then 1FFF (TAIL) until IDLE.
//  3 cod_len=0, chip_len=0 -> 64 chips of 1 sample each, chip_idx 0..63, code_done at rise+65.
//  4 sinc dropped after 5 samples of test 2 config -> 5 modulated samples, then 1FFF.
//    code_done never asserted, busy falls 2 clk after the fall.
//  5 cod changed to 0 mid-pulse -> output unchanged from test 2 pattern. A 1-clk sinc low gap
//    followed by a rise restarts at chip 0.
//  6 GOLAY_PAIR_EN: cod=4'b1101, cod_b=4'b1110, three pulses -> code_sel=0,1,0 and bit patterns
//    A,B,A. An aborted second pulse still advances to cod_b->cod.

Source files
------------

// File: rtl/modulador_pcode_pkg.sv
// rtl/modulador_pcode_pkg.sv - shared FSM encoding and midscale helper for the phase-code modulator
// Contents:
//   pcode_state_t  sequencer states (IDLE / RUN / TAIL)
//   midscale()     offset-binary midscale value for a given sample width
package modulador_pcode_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_TAIL = 2'd2
   } pcode_state_t;

   function automatic logic [31:0] midscale(input int width);
      return (32'd1 << (width - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/modulador_pcode_chip_seq.sv
// rtl/modulador_pcode_chip_seq.sv - code sequencer: FSM, config latch, sample/chip counters, current bit
// Optional feature macro: GOLAY_PAIR_EN (adds cod_b input and code_sel output)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sinc              pulse gate
//   cod [, cod_b]     code word(s), MSB of the used field first
//   cod_len           chips per pulse (0 or >CODE_W means CODE_W)
//   chip_len          samples per chip (0 means 1)
//   code_bit          code bit for the sample taken this clk
//   active            sample taken this clk belongs to the code
//   chip_idx          chip index of that sample (0 when inactive)
//   last              sample is the final one of the final chip
//   [code_sel]        0 = cod, 1 = cod_b for the current pulse
module modulador_pcode_chip_seq
   import modulador_pcode_pkg::*;
#(
   parameter int CODE_W = 64,
   parameter int LEN_W  = 7,
   parameter int CHIP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sinc,
   input  logic [CODE_W-1:0] cod,
`ifdef GOLAY_PAIR_EN
   input  logic [CODE_W-1:0] cod_b,
   output logic              code_sel,
`endif
   input  logic [LEN_W-1:0]  cod_len,
   input  logic [CHIP_W-1:0] chip_len,
   output logic              code_bit,
   output logic              active,
   output logic [LEN_W-1:0]  chip_idx,
   output logic              last
);

   localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(CODE_W);

   pcode_state_t      state, state_nx;
   logic              sinc_d;
   logic [CODE_W-1:0] cod_l, cod_l_nx;
   logic [LEN_W-1:0]  len_l, len_l_nx, chip_cnt, chip_cnt_nx;
   logic [CHIP_W-1:0] chip_l, chip_l_nx, samp_cnt, samp_cnt_nx;
`ifdef GOLAY_PAIR_EN
   logic              sel_next, sel_next_nx, sel_l, sel_l_nx;
`endif

   logic              rise, start, run_now, last_now, last_samp;
   logic [CODE_W-1:0] cod_in, use_cod;
   logic [LEN_W-1:0]  use_len, cur_chip;
   logic [CHIP_W-1:0] use_chip, cur_samp;
   logic [IDX_W-1:0]  bit_pos;

   // sinc_d follows sinc even during reset, so a gate held high through
   // reset is not mistaken for a fresh rising edge afterwards.
   always_ff @(posedge clk) begin
      sinc_d <= sinc;
      if (rst) begin
         state    <= ST_IDLE;
         cod_l    <= '0;
         len_l    <= '0;
         chip_l   <= '0;
         chip_cnt <= '0;
         samp_cnt <= '0;
`ifdef GOLAY_PAIR_EN
         sel_next <= 1'b0;
         sel_l    <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         cod_l    <= cod_l_nx;
         len_l    <= len_l_nx;
         chip_l   <= chip_l_nx;
         chip_cnt <= chip_cnt_nx;
         samp_cnt <= samp_cnt_nx;
`ifdef GOLAY_PAIR_EN
         sel_next <= sel_next_nx;
         sel_l    <= sel_l_nx;
`endif
      end
   end

   // On the start edge the live inputs stand in for the latch so that the
   // rising-edge sample is already chip 0, sample 0.
   always_comb begin
`ifdef GOLAY_PAIR_EN
      cod_in = sel_next ? cod_b : cod;
`else
      cod_in = cod;
`endif
      rise     = sinc & ~sinc_d;
      start    = (state == ST_IDLE) && rise;
      use_cod  = start ? cod_in : cod_l;
      use_len  = start ? (((cod_len == '0) || (cod_len > MAX_LEN)) ? MAX_LEN : cod_len) : len_l;
      use_chip = start ? ((chip_len == '0) ? CHIP_W'(1) : chip_len) : chip_l;
      cur_chip = start ? '0 : chip_cnt;
      cur_samp = start ? '0 : samp_cnt;
      run_now  = start || ((state == ST_RUN) && sinc);
      last_samp = (cur_samp == use_chip - CHIP_W'(1));
      last_now = run_now && last_samp && (cur_chip == use_len - LEN_W'(1));
      bit_pos  = IDX_W'(use_len - cur_chip - LEN_W'(1));
   end

   always_comb begin
      state_nx    = state;
      cod_l_nx    = cod_l;
      len_l_nx    = len_l;
      chip_l_nx   = chip_l;
      chip_cnt_nx = chip_cnt;
      samp_cnt_nx = samp_cnt;
`ifdef GOLAY_PAIR_EN
      sel_next_nx = sel_next;
      sel_l_nx    = sel_l;
`endif
      case (state)
         ST_IDLE: if (start) state_nx = last_now ? ST_TAIL : ST_RUN;
         ST_RUN: begin
            if (!sinc)         state_nx = ST_IDLE;
            else if (last_now) state_nx = ST_TAIL;
         end
         ST_TAIL: if (!sinc) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      if (start) begin
         cod_l_nx  = use_cod;
         len_l_nx  = use_len;
         chip_l_nx = use_chip;
`ifdef GOLAY_PAIR_EN
         sel_l_nx    = sel_next;
         sel_next_nx = ~sel_next;
`endif
      end
      if (run_now) begin
         if (last_samp) begin
            samp_cnt_nx = '0;
            chip_cnt_nx = cur_chip + LEN_W'(1);
         end else begin
            samp_cnt_nx = cur_samp + CHIP_W'(1);
            chip_cnt_nx = cur_chip;
         end
      end
   end

   always_comb begin
      active   = run_now;
      chip_idx = run_now ? cur_chip : '0;
      code_bit = run_now & use_cod[bit_pos];
      last     = last_now;
`ifdef GOLAY_PAIR_EN
      code_sel = start ? sel_next : sel_l;
`endif
   end

endmodule

// File: rtl/modulador_pcode.sv
// rtl/modulador_pcode.sv - phase-code (BPSK) pulse modulator between carrier source and DAC
// Optional feature macro: GOLAY_PAIR_EN (alternating cod / cod_b pulses, code_sel status)
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   sinc         pulse gate; rising edge starts a code, low forces midscale
//   cod          code bits (chip i uses cod[cod_len-1-i])
//   [cod_b]      second code of the pair
//   cod_len      chips per pulse; chip_len samples per chip
//   senial       offset-binary carrier sample
//   senial_mod   modulated sample to DAC (2 clk latency)
//   chip_idx     chip index of the sample on senial_mod
//   busy         senial_mod carries code samples
//   code_done    pulse on the last sample of the last chip
//   [code_sel]   code of the pair on senial_mod
module modulador_pcode
   import modulador_pcode_pkg::*;
#(
   parameter int DATA_W = 14,
   parameter int CODE_W = 64,
   parameter int LEN_W  = 7,
   parameter int CHIP_W = 16,
   parameter logic [DATA_W-1:0] ZERO = DATA_W'(midscale(DATA_W))
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sinc,
   input  logic [CODE_W-1:0] cod,
`ifdef GOLAY_PAIR_EN
   input  logic [CODE_W-1:0] cod_b,
   output logic              code_sel,
`endif
   input  logic [LEN_W-1:0]  cod_len,
   input  logic [CHIP_W-1:0] chip_len,
   input  logic [DATA_W-1:0] senial,
   output logic [DATA_W-1:0] senial_mod,
   output logic [LEN_W-1:0]  chip_idx,
   output logic              busy,
   output logic              code_done
);

   logic             seq_bit, seq_active, seq_last;
   logic [LEN_W-1:0] seq_idx;

   logic [DATA_W-1:0] s1_data;
   logic              s1_bit, s1_act, s1_last;
   logic [LEN_W-1:0]  s1_idx;
`ifdef GOLAY_PAIR_EN
   logic              seq_sel, s1_sel;
`endif

   modulador_pcode_chip_seq #(
      .CODE_W (CODE_W),
      .LEN_W  (LEN_W),
      .CHIP_W (CHIP_W)
   ) u_seq (
      .clk      (clk),
      .rst      (rst),
      .sinc     (sinc),
      .cod      (cod),
`ifdef GOLAY_PAIR_EN
      .cod_b    (cod_b),
      .code_sel (seq_sel),
`endif
      .cod_len  (cod_len),
      .chip_len (chip_len),
      .code_bit (seq_bit),
      .active   (seq_active),
      .chip_idx (seq_idx),
      .last     (seq_last)
   );

   // Stage 1: sample and its sequencer decision captured together.
   // Stage 2: mix; bitwise inversion mirrors offset-binary about midscale.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_data    <= '0;
         s1_bit     <= 1'b0;
         s1_act     <= 1'b0;
         s1_last    <= 1'b0;
         s1_idx     <= '0;
         senial_mod <= ZERO;
         chip_idx   <= '0;
         busy       <= 1'b0;
         code_done  <= 1'b0;
`ifdef GOLAY_PAIR_EN
         s1_sel     <= 1'b0;
         code_sel   <= 1'b0;
`endif
      end else begin
         s1_data    <= senial;
         s1_bit     <= seq_bit;
         s1_act     <= seq_active;
         s1_last    <= seq_last;
         s1_idx     <= seq_idx;
         senial_mod <= s1_act ? (s1_bit ? s1_data : ~s1_data) : ZERO;
         chip_idx   <= s1_act ? s1_idx : '0;
         busy       <= s1_act;
         code_done  <= s1_act & s1_last;
`ifdef GOLAY_PAIR_EN
         s1_sel     <= seq_sel;
         code_sel   <= s1_act & s1_sel;
`endif
      end
   end

endmodule

// File: tb/tb_modulador_pcode.sv
// tb/tb_modulador_pcode.sv - self-checking bench for modulador_pcode with a behavioural pulse model
module tb_modulador_pcode;

   localparam logic [13:0] ZERO = 14'h1FFF;

   logic        clk = 1'b0;
   logic        rst, sinc;
   logic [63:0] cod;
   logic [6:0]  cod_len;
   logic [15:0] chip_len;
   logic [13:0] senial;
   logic [13:0] senial_mod;
   logic [6:0]  chip_idx;
   logic        busy, code_done;
`ifdef GOLAY_PAIR_EN
   logic [63:0] cod_b;
   logic        code_sel;
`endif

   always #5 clk = ~clk;

   modulador_pcode dut (
      .clk        (clk),
      .rst        (rst),
      .sinc       (sinc),
      .cod        (cod),
`ifdef GOLAY_PAIR_EN
      .cod_b      (cod_b),
      .code_sel   (code_sel),
`endif
      .cod_len    (cod_len),
      .chip_len   (chip_len),
      .senial     (senial),
      .senial_mod (senial_mod),
      .chip_idx   (chip_idx),
      .busy       (busy),
      .code_done  (code_done)
   );

   typedef struct {
      logic [13:0] out;
      logic [6:0]  idx;
      logic        busy;
      logic        done;
      logic        sel;
   } exp_t;

   int checks = 0;
   int errors = 0;

   // model state: a pulse is a sample counter k over len*clen samples
   bit          m_prev_sinc, m_in, m_sel, m_sel_next;
   int          m_k, m_len, m_clen;
   logic [63:0] m_cod;
   exp_t        e1, e2;
   bit          rand_sen;
   int          done_cnt = 0;

   logic [13:0] log_out  [0:15];
   logic        log_busy [0:15];
   logic        log_done [0:15];
   logic [6:0]  log_idx  [0:15];
   logic        log_sel  [0:15];
   logic [13:0] pat2     [0:7];
   logic [13:0] pat_a    [0:3];
   logic [13:0] pat_b    [0:3];

   function automatic exp_t idle_exp();
      exp_t e;
      e.out = ZERO; e.idx = '0; e.busy = 1'b0; e.done = 1'b0; e.sel = 1'b0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      exp_t s;
      bit   rise;
      int   chip;
      s = idle_exp();
      if (rst) begin
         m_in = 0; m_sel_next = 0; m_sel = 0;
         m_prev_sinc = sinc;
         e1 = idle_exp(); e2 = idle_exp();
         return;
      end
      rise = sinc && !m_prev_sinc;
      m_prev_sinc = sinc;
      if (!sinc) m_in = 0;
      else if (!m_in && rise) begin
         m_in = 1; m_k = 0;
         m_sel = m_sel_next; m_sel_next = !m_sel_next;
         m_cod = cod;
`ifdef GOLAY_PAIR_EN
         if (m_sel) m_cod = cod_b;
`endif
         m_len  = (cod_len == 0 || cod_len > 64) ? 64 : int'(cod_len);
         m_clen = (chip_len == 0) ? 1 : int'(chip_len);
      end
      if (m_in) begin
         chip   = m_k / m_clen;
         s.out  = m_cod[m_len - 1 - chip] ? senial : ~senial;
         s.idx  = 7'(chip);
         s.busy = 1'b1;
         s.sel  = m_sel;
         if (m_k == m_len * m_clen - 1) begin
            s.done = 1'b1;
            m_in = 0;
         end else m_k++;
      end
      e2 = e1;
      e1 = s;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("senial_mod", 64'(senial_mod), 64'(e2.out));
      chk("busy", 64'(busy), 64'(e2.busy));
      chk("chip_idx", 64'(chip_idx), 64'(e2.idx));
      chk("code_done", 64'(code_done), 64'(e2.done));
`ifdef GOLAY_PAIR_EN
      chk("code_sel", 64'(code_sel), 64'(e2.sel));
`endif
      if (code_done) done_cnt++;
      if (rand_sen) senial = 14'($urandom);
   endtask

   task automatic cyc_log(input int j);
      cyc();
      log_out[j]  = senial_mod;
      log_busy[j] = busy;
      log_done[j] = code_done;
      log_idx[j]  = chip_idx;
`ifdef GOLAY_PAIR_EN
      log_sel[j]  = code_sel;
`else
      log_sel[j]  = 1'b0;
`endif
   endtask

   task automatic cfg_t2();
      cod = 64'hB; cod_len = 7'd4; chip_len = 16'd2;
      senial = 14'h2000; rand_sen = 0;
   endtask

   initial begin
      int d0, done_j, hi, lo;
      logic [6:0] idx64;
      pat2[0] = 14'h2000; pat2[1] = 14'h2000; pat2[2] = 14'h1FFF; pat2[3] = 14'h1FFF;
      pat2[4] = 14'h2000; pat2[5] = 14'h2000; pat2[6] = 14'h2000; pat2[7] = 14'h2000;
      pat_a[0] = 14'h2000; pat_a[1] = 14'h2000; pat_a[2] = 14'h1FFF; pat_a[3] = 14'h2000;
      pat_b[0] = 14'h2000; pat_b[1] = 14'h2000; pat_b[2] = 14'h2000; pat_b[3] = 14'h1FFF;

      // reset with sinc held high; no run afterwards until a fresh rise
      rst = 1; sinc = 1; rand_sen = 1;
      cod = {$urandom, $urandom}; cod_len = 7'd4; chip_len = 16'd1;
      senial = 14'($urandom);
`ifdef GOLAY_PAIR_EN
      cod_b = {$urandom, $urandom};
`endif
      for (int i = 0; i < 3; i++) cyc();
      chk("t1_reset_out", 64'(senial_mod), 64'(ZERO));
      chk("t1_reset_busy", 64'(busy), 64'd0);
      rst = 0;
      for (int i = 0; i < 5; i++) cyc();
      chk("t1_no_run", 64'(busy), 64'd0);
      sinc = 0; cyc();

      // basic 4-chip code, 2 samples per chip, 12-clk gate
      cfg_t2(); cyc();
      d0 = done_cnt;
      sinc = 1;
      for (int j = 0; j < 12; j++) cyc_log(j);
      sinc = 0;
      for (int j = 1; j <= 8; j++) chk("t2_pattern", 64'(log_out[j]), 64'(pat2[j-1]));
      chk("t2_done_at_8", 64'(log_done[8]), 64'd1);
      chk("t2_done_once", 64'(done_cnt - d0), 64'd1);
      for (int j = 9; j < 12; j++) chk("t2_tail", 64'(log_out[j]), 64'(ZERO));
      cyc(); cyc();

      // full-width code with defaulted lengths
      cod = {$urandom, $urandom}; cod_len = 7'd0; chip_len = 16'd0; rand_sen = 1;
      sinc = 1; done_j = -1; idx64 = '0;
      for (int j = 0; j < 70; j++) begin
         cyc();
         if (code_done && done_j < 0) done_j = j;
         if (j == 64) idx64 = chip_idx;
      end
      chk("t3_done_at", 64'(done_j), 64'd64);
      chk("t3_last_idx", 64'(idx64), 64'd63);
      sinc = 0; cyc(); cyc();

      // abort after 5 samples
      cfg_t2(); d0 = done_cnt;
      sinc = 1;
      for (int j = 0; j < 10; j++) begin
         if (j == 5) sinc = 0;
         cyc_log(j);
      end
      chk("t4_busy_last", 64'(log_busy[5]), 64'd1);
      chk("t4_busy_fall", 64'(log_busy[6]), 64'd0);
      chk("t4_out_idle", 64'(log_out[6]), 64'(ZERO));
      chk("t4_no_done", 64'(done_cnt - d0), 64'd0);

      // config changes mid-pulse are ignored; 1-clk gap restarts at chip 0
      cfg_t2(); sinc = 1;
      for (int j = 0; j < 12; j++) begin
         cyc_log(j);
         if (j == 3) begin cod = 64'h0; cod_len = 7'd1; chip_len = 16'd5; end
      end
      for (int j = 1; j <= 8; j++) chk("t5_pattern", 64'(log_out[j]), 64'(pat2[j-1]));
      sinc = 0; cyc_log(0);
      sinc = 1; cyc_log(0); cyc_log(1);
      chk("t5_restart_busy", 64'(log_busy[1]), 64'd1);
      chk("t5_restart_idx", 64'(log_idx[1]), 64'd0);
      chk("t5_restart_out", 64'(log_out[1]), 64'(ZERO));
      for (int j = 0; j < 6; j++) cyc();
      sinc = 0; cyc(); cyc();

      // randomized pulses, including aborts, mid-pulse config churn and resets
      rand_sen = 1;
      for (int p = 0; p < 40; p++) begin
         cod = {$urandom, $urandom};
`ifdef GOLAY_PAIR_EN
         cod_b = {$urandom, $urandom};
`endif
         cod_len = 7'($urandom_range(0, 70));
         chip_len = 16'($urandom_range(0, 3));
         hi = $urandom_range(1, 90);
         lo = $urandom_range(1, 4);
         sinc = 1;
         for (int j = 0; j < hi; j++) begin
            cyc();
            if ($urandom_range(0, 15) == 0) cod = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) cod_len = 7'($urandom_range(0, 70));
            rst = ($urandom_range(0, 299) == 0);
         end
         rst = 0;
         sinc = 0;
         for (int j = 0; j < lo; j++) cyc();
      end

`ifdef GOLAY_PAIR_EN
      // A, B, A, then B aborted, then A again
      rst = 1; cyc(); cyc(); rst = 0;
      cod = 64'b1101; cod_b = 64'b1110; cod_len = 7'd4; chip_len = 16'd1;
      senial = 14'h2000; rand_sen = 0;
      for (int p = 0; p < 5; p++) begin
         sinc = 1;
         for (int j = 0; j < 6; j++) begin
            if (p == 3 && j == 2) sinc = 0;
            cyc_log(j);
         end
         sinc = 0; cyc(); cyc();
         chk("t6_sel", 64'(log_sel[1]), 64'(p % 2));
         if (p != 3)
            for (int j = 1; j <= 4; j++)
               chk("t6_pattern", 64'(log_out[j]), 64'((p % 2) ? pat_b[j-1] : pat_a[j-1]));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
